event_queue_ctrl: RTL and testbench
===================================

# event_queue_ctrl

Controller for the event-queue SRAM in the DVS→Ravens path. It accepts events from the DVS capture logic and writes them into the single-port event SRAM. It reads them back in FIFO order and presents them to the Ravens-side consumer over a valid/ready handshake. It owns the write/read pointers, occupancy tracking, full/empty status and read/write arbitration of the one SRAM port.

## Interface
Parameters:
- DEPTH, default EVENT_QUEUE_DEPTH: SRAM word count; need not be a power of two.
- WIDTH, default EVENT_BITS: event word width.
- OVF_CNT_BITS, default 16: dropped-event counter width.

Ports:
- clk  in  1: single clock; all flops on posedge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: an event is present this cycle; the source cannot stall.
- in_event  in  WIDTH: event data.
- out_valid  out  1: out_event is valid.
- out_event  out  WIDTH: head-of-queue event.
- out_ready  in  1: consumer accepts when out_valid && out_ready.
- full  out  1: SRAM occupancy == DEPTH.
- empty  out  1: no events stored, in flight, or held.
- level  out  $clog2(DEPTH+1): SRAM occupancy, i.e. written but not yet read-issued.
- drop_count  out  OVF_CNT_BITS: events dropped while full.
- sram_addr  out  $clog2(DEPTH): to SRAM addr.
- sram_din  out  WIDTH: to SRAM din; equals in_event.
- sram_wr_en  out  1: to SRAM wr_en.
- sram_sense_en  out  1: to SRAM sense_en.
- sram_dout  in  WIDTH: from SRAM dout; registered, valid the cycle after sense_en.

## Operation
- **Write.** sram_wr_en = in_valid && !full.
  - sram_addr = wr_ptr.
  - On the edge: wr_ptr advances and level increments.
- **Drop.** An event arriving with in_valid && full is discarded. It is counted per Configuration.
- **Read issue.** sram_sense_en = !sram_wr_en && level != 0 && (state == IDLE || (state == HOLD && out_ready)).
  - sram_addr = rd_ptr.
  - On the edge: rd_ptr advances and level decrements.
- **Write priority.** The write always wins the port. A read blocked by a write retries the next cycle. Continuous writes can defer reads until full, and then reads proceed.
- **Pointers.** Each wraps DEPTH-1 → 0 by explicit compare, not modulo-2^n.
- **level.** Same-cycle write and read issue is impossible, so level changes by at most ±1 per cycle.
- **Output FSM:**
  - IDLE: out_valid=0. Goes to FETCH when sense_en is asserted.
  - FETCH: the read is in flight. out_event ← sram_dout on the edge, then go to HOLD unconditionally.
  - HOLD: out_valid=1, out_event stable. On out_ready it goes to FETCH if sense_en is asserted this cycle, else to IDLE. Without out_ready it stays in HOLD.
- **Status.** empty = (level == 0) && state == IDLE. full is combinational from level.

## Timing
- **Reset values** (asynchronous): wr_ptr=0, rd_ptr=0, level=0, state=IDLE, out_valid=0, out_event=0, drop_count=0.
  - Status outputs at reset: full=0, empty=1.
  - SRAM control at reset: sram_wr_en=0, sram_sense_en=0.
- **Reset mid-operation:** all queued and held events are discarded. SRAM contents are don't-care afterwards.
- **Latency, empty queue:** in_valid in cycle 0 → write at edge 0 → sense in cycle 1 → FETCH in cycle 2 → out_valid in cycle 3.
- **Sustained throughput:** one event per 2 cycles (HOLD→FETCH→HOLD) with out_ready held high and no writes.
- **Handshake:** out_event never changes while out_valid && !out_ready.
- **Write/status timing:** a write in the same cycle as full=1 is dropped. full deasserts the cycle after a read issue.

## Configuration
- EVENT_QUEUE_OVERFLOW_CNT_EN defined:
  - drop_count increments on every dropped event.
  - It saturates at 2^OVF_CNT_BITS-1.
  - It is cleared only by rst.
- Undefined: drop_count is tied to 0, with no counter flops. The port list is unchanged.

## Structure
- dvs_ravens_pkg holds:
  - EVENT_QUEUE_DEPTH and EVENT_BITS, already present.
  - The state enum typedef eq_state_t {IDLE, FETCH, HOLD}.
  - The constant EVENT_QUEUE_OVF_CNT_BITS = 16.
- One sub-module: event_queue_ptr. It is a wrapping pointer with an advance input, instantiated twice (write and read).
- The SRAM is instantiated by the parent and connected via the sram_* ports.

## Test plan
Bench uses DEPTH=4.
- **Single event.** Reset, then in_valid one cycle with in_event=0xA5, out_ready=1. Required: out_valid=1 with out_event=0xA5 in cycle 3; empty=1 afterwards.
- **Fill and drop.** Write 0x1, 0x2, 0x3, 0x4, 0x5, 0x6 on consecutive cycles with out_ready=0. Required:
  - full=1 after the 4th write; reads are deferred while writes continue.
  - 5th and 6th events dropped; drop_count=2 with the macro, 0 without.
  - Drain yields 1, 2, 3, 4 in order.
- **Backpressure.** Queue 0x11, 0x22, hold out_ready=0 for 10 cycles. Required: out_event stays 0x11 throughout; after release, 0x22 follows two cycles later.
- **Port conflict.** With 0x33 queued and the output in IDLE, drive in_valid every cycle for 3 cycles. Required: sense_en stays low during those writes; the read issues on the first idle cycle; FIFO order is preserved.
- **Wrap-around.** Push and pop 10 events 0x00–0x09 at one per 2 cycles. Required: pointers wrap 3→0 and output order is exact.
- **Async reset in FETCH.** Assert rst mid-operation. Required: out_valid=0, level=0, empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dvs_ravens_pkg.sv
// Shared DVS->Ravens definitions: queue geometry, event width, state encoding.
// Consumed by event_queue_ctrl and its pointer sub-module.
package dvs_ravens_pkg;

    localparam int EVENT_QUEUE_DEPTH        = 2048;
    localparam int EVENT_BITS               = 32;
    localparam int EVENT_QUEUE_OVF_CNT_BITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } eq_state_t;

endpackage

// File: rtl/event_queue_ptr.sv
// Wrapping SRAM pointer for the event queue; wraps DEPTH-1 -> 0 by compare,
// so DEPTH need not be a power of two.
module event_queue_ptr #(
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/event_queue_ctrl.sv
// Event-queue SRAM controller: FIFO over a single-port SRAM, write-priority.
// Define EVENT_QUEUE_OVERFLOW_CNT_EN to build the saturating drop counter.
module event_queue_ctrl
    import dvs_ravens_pkg::*;
#(
    parameter int DEPTH        = EVENT_QUEUE_DEPTH,
    parameter int WIDTH        = EVENT_BITS,
    parameter int OVF_CNT_BITS = EVENT_QUEUE_OVF_CNT_BITS,
    localparam int AW          = $clog2(DEPTH),
    localparam int LW          = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_event,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_event,
    input  logic                    out_ready,
    output logic                    full,
    output logic                    empty,
    output logic [LW-1:0]           level,
    output logic [OVF_CNT_BITS-1:0] drop_count,
    output logic [AW-1:0]           sram_addr,
    output logic [WIDTH-1:0]        sram_din,
    output logic                    sram_wr_en,
    output logic                    sram_sense_en,
    input  logic [WIDTH-1:0]        sram_dout
);

    eq_state_t        state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] event_q, event_d;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_go, rd_go;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0) && (state_q == IDLE);
    assign wr_go = in_valid && !full;
    assign rd_go = !wr_go && (level_q != '0) &&
                   ((state_q == IDLE) || ((state_q == HOLD) && out_ready));

    assign sram_wr_en    = wr_go;
    assign sram_sense_en = rd_go;
    assign sram_addr     = wr_go ? wr_ptr : rd_ptr;
    assign sram_din      = in_event;
    assign level         = level_q;
    assign out_valid     = (state_q == HOLD);
    assign out_event     = event_q;

    event_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .adv_i (wr_go),
        .ptr_o (wr_ptr)
    );

    event_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .adv_i (rd_go),
        .ptr_o (rd_ptr)
    );

    // wr_go and rd_go are mutually exclusive, so level moves by at most one
    always_comb begin
        level_d = level_q;
        state_d = state_q;
        event_d = event_q;
        if (wr_go) level_d = level_q + LW'(1);
        if (rd_go) level_d = level_q - LW'(1);
        unique case (state_q)
            IDLE:  if (rd_go) state_d = FETCH;
            FETCH: begin
                event_d = sram_dout;
                state_d = HOLD;
            end
            HOLD:  if (out_ready) state_d = rd_go ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= '0;
            event_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            event_q <= event_d;
        end
    end

`ifdef EVENT_QUEUE_OVERFLOW_CNT_EN
    logic [OVF_CNT_BITS-1:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (in_valid && full && (drop_q != '1)) drop_d = drop_q + OVF_CNT_BITS'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_event_queue_ctrl.sv
// Scoreboard bench for event_queue_ctrl (DEPTH=4, 8-bit events) with a
// behavioural SRAM and an occupancy/stage reference model.
module tb_event_queue_ctrl;

    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int OB    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_event;
    logic          out_valid;
    logic [W-1:0]  out_event;
    logic          out_ready;
    logic          full;
    logic          empty;
    logic [2:0]    level;
    logic [OB-1:0] drop_count;
    logic [1:0]    sram_addr;
    logic [W-1:0]  sram_din;
    logic          sram_wr_en;
    logic          sram_sense_en;
    logic [W-1:0]  sram_dout;

    int n_cmp = 0;
    int n_bad = 0;

    event_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(W), .OVF_CNT_BITS(OB)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_event      (in_event),
        .out_valid     (out_valid),
        .out_event     (out_event),
        .out_ready     (out_ready),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .drop_count    (drop_count),
        .sram_addr     (sram_addr),
        .sram_din      (sram_din),
        .sram_wr_en    (sram_wr_en),
        .sram_sense_en (sram_sense_en),
        .sram_dout     (sram_dout)
    );

    always #5 clk = ~clk;

    // behavioural single-port SRAM with registered read data
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (sram_wr_en) mem[sram_addr] <= sram_din;
        if (sram_sense_en) sram_dout <= mem[sram_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: events stored in SRAM, output stage (0 empty, 1 fetch, 2 held)
    logic [W-1:0] exp_q[$];
    int m_level = 0;
    int m_stage = 0;
    int m_drop  = 0;

    always @(negedge clk) begin
        bit w, r;
        if (rst) begin
            m_level = 0;
            m_stage = 0;
            m_drop  = 0;
            exp_q.delete();
        end else begin
            w = in_valid && (m_level < DEPTH);
            r = !w && (m_level > 0) &&
                (m_stage == 0 || (m_stage == 2 && out_ready));
            chk("level", int'(level), m_level);
            chk("full", int'(full), int'(m_level == DEPTH));
            chk("empty", int'(empty), int'(m_level == 0 && m_stage == 0));
            chk("out_valid", int'(out_valid), int'(m_stage == 2));
            chk("wr_en", int'(sram_wr_en), int'(w));
            chk("sense_en", int'(sram_sense_en), int'(r));
            chk("drop_count", int'(drop_count), m_drop);
            if (w) begin
                exp_q.push_back(in_event);
                m_level++;
            end
`ifdef EVENT_QUEUE_OVERFLOW_CNT_EN
            if (in_valid && !w && m_drop < (1 << OB) - 1) m_drop++;
`endif
            if (r) m_level--;
            case (m_stage)
                0: m_stage = r ? 1 : 0;
                1: m_stage = 2;
                default: if (out_ready) m_stage = r ? 1 : 0;
            endcase
        end
    end

    // output monitor: pops the scoreboard on each accepted event
    logic         held_prev = 1'b0;
    logic [W-1:0] ev_prev   = '0;

    always @(negedge clk) begin
        if (rst) begin
            held_prev = 1'b0;
        end else begin
            if (out_valid && held_prev)
                chk("stable", int'(out_event), int'(ev_prev));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("underflow", 1, 0);
                else chk("data", int'(out_event), int'(exp_q.pop_front()));
            end
            held_prev = out_valid && !out_ready;
            ev_prev   = out_event;
        end
    end

    task automatic cyc(input bit v, input logic [W-1:0] e, input bit rdy);
        in_valid  = v;
        in_event  = e;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) cyc(1'b0, '0, rdy);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_event  = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_event", int'(out_event), 0);
        chk("rst_wr_en", int'(sram_wr_en), 0);
        chk("rst_sense_en", int'(sram_sense_en), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2, 1'b1);

        // single event, latency 3
        cyc(1'b1, 8'hA5, 1'b1);
        idle(5, 1'b1);

        // fill and drop with reads deferred by writes
        for (int i = 1; i <= 6; i++) cyc(1'b1, W'(i), 1'b0);
        idle(4, 1'b0);
        idle(12, 1'b1);

        // backpressure
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        idle(10, 1'b0);
        idle(6, 1'b1);

        // port conflict
        cyc(1'b1, 8'h33, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, W'(8'h40 + i), 1'b1);
        idle(12, 1'b1);

        // wrap-around at one per two cycles
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, W'(i), 1'b1);
            cyc(1'b0, '0, 1'b1);
        end
        idle(8, 1'b1);

        // async reset while FETCH
        cyc(1'b1, 8'h5A, 1'b1);
        cyc(1'b0, '0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_empty", int'(empty), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2, 1'b1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) < 55, W'($urandom), $urandom_range(0, 99) < 60);
        end

        // bounded drain
        for (int i = 0; i < 60; i++) begin
            if (empty && exp_q.size() == 0) break;
            cyc(1'b0, '0, 1'b1);
        end
        @(negedge clk);
        #1;
        chk("drain_left", exp_q.size(), 0);
        chk("drain_empty", int'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
